// File: rtl/mem_spi_target.sv
`default_nettype none
// ============================================================================
//  Module   : mem_spi_target
//  Purpose  : SPI (mode 3) memory target that bridges single and quad SPI
//             read/program/status commands onto a simple byte-wide
//             backing-memory port. It oversamples SCLK with the system clock.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk             in   system clock (single domain)
//    rst_n           in   asynchronous active-low reset
//    in_sclk         in   SPI clock, idle high, synchronous to clk
//    in_cs_n         in   chip select, active low
//    in_io[3:0]      in   IO pins from initiator (io0 = DI in single mode)
//    out_io[3:0]     out  IO pins driven by target (io1 = DO in single mode)
//    io_ena[3:0]     out  per-pin output enable, 1 = target drives
//    out_mem_addr    out  backing-memory byte address
//    out_mem_rd_en   out  one-cycle read strobe, data taken in same cycle
//    in_mem_rd_data  in   zero-latency read data
//    out_mem_wr_en   out  one-cycle write strobe
//    out_mem_wr_data out  write data, valid with out_mem_wr_en
// ============================================================================
module mem_spi_target #(
    parameter int ADDR_W = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_sclk,
    input  logic              in_cs_n,
    input  logic [3:0]        in_io,
    output logic [3:0]        out_io,
    output logic [3:0]        io_ena,
    output logic [ADDR_W-1:0] out_mem_addr,
    output logic              out_mem_rd_en,
    input  logic [7:0]        in_mem_rd_data,
    output logic              out_mem_wr_en,
    output logic [7:0]        out_mem_wr_data
);

    localparam logic [7:0] c_op_read  = 8'h03;
    localparam logic [7:0] c_op_qread = 8'h6B;
    localparam logic [7:0] c_op_prog  = 8'h02;
    localparam logic [7:0] c_op_qprog = 8'h32;
    localparam logic [7:0] c_op_wren  = 8'h06;
    localparam logic [7:0] c_op_rdsr  = 8'h05;

    localparam logic [ADDR_W-1:0] c_addr_one = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_ADDR    = 3'd2,
        ST_DUMMY   = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_WR_DATA = 3'd5,
        ST_STATUS  = 3'd6,
        ST_IGNORE  = 3'd7
    } state_t;

    state_t            state_q, state_d;
    logic              sclk_q;
    logic              cs_n_q;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [3:0]        rise_cnt_q, rise_cnt_d;
    logic [22:0]       sr_q, sr_d;
    logic [7:0]        cmd_q, cmd_d;
    logic              quad_q, quad_d;
    logic [7:0]        tx_q, tx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_en_q, rd_en_d;
    logic              wr_en_q, wr_en_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic [3:0]        io_q, io_d;
    logic [3:0]        ena_q, ena_d;
    logic              wel_q, wel_d;
    logic              wr_seen_q, wr_seen_d;

    logic              w_rise;
    logic              w_fall;
    logic              w_cs_fall;
    logic [23:0]       w_sr_bit;
    logic [22:0]       w_sr_nib;
    logic [7:0]        w_status;
    logic [ADDR_W-1:0] w_addr_in;

    assign w_rise    = in_sclk & ~sclk_q;
    assign w_fall    = ~in_sclk & sclk_q;
    assign w_cs_fall = cs_n_q & ~in_cs_n;
    assign w_sr_bit  = {sr_q, in_io[0]};
    assign w_sr_nib  = {sr_q[18:0], in_io};
    assign w_status  = {6'b000000, wel_q, 1'b0};

    // The wire always carries 24 address bits; keep only what the memory uses.
    generate
        if (ADDR_W <= 24) begin : g_addr_narrow
            assign w_addr_in = w_sr_bit[ADDR_W-1:0];
        end else begin : g_addr_wide
            assign w_addr_in = {{(ADDR_W-24){1'b0}}, w_sr_bit};
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rise_cnt_d = rise_cnt_q;
        sr_d       = sr_q;
        cmd_d      = cmd_q;
        quad_d     = quad_q;
        tx_d       = tx_q;
        addr_d     = addr_q;
        rd_en_d    = 1'b0;
        wr_en_d    = 1'b0;
        wr_data_d  = wr_data_q;
        io_d       = io_q;
        ena_d      = ena_q;
        wel_d      = wel_q;
        wr_seen_d  = wr_seen_q;

        // Prefetched byte is captured while the read strobe is presented.
        if (rd_en_q) begin
            tx_d = in_mem_rd_data;
        end
        // Advance within the 256-byte page once the write has been presented.
        if (wr_en_q) begin
            addr_d[7:0] = addr_q[7:0] + 8'd1;
        end

        if (in_cs_n) begin
            state_d = ST_IDLE;
            io_d    = 4'b0000;
            ena_d   = 4'b0000;
            // First cycle of CS high after a transaction: commit WEL changes.
            if (state_q != ST_IDLE) begin
                if ((cmd_q == c_op_wren) && (rise_cnt_q == 4'd8)) begin
                    wel_d = 1'b1;
                end
                if (wr_seen_q) begin
                    wel_d = 1'b0;
                end
            end
        end else begin
            if (w_rise && (state_q != ST_IDLE) && (rise_cnt_q != 4'hF)) begin
                rise_cnt_d = rise_cnt_q + 4'd1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (w_cs_fall) begin
                        state_d    = ST_CMD;
                        bit_cnt_d  = 5'd0;
                        rise_cnt_d = 4'd0;
                        sr_d       = 23'd0;
                        cmd_d      = 8'h00;
                        quad_d     = 1'b0;
                        wr_seen_d  = 1'b0;
                    end
                end

                ST_CMD: begin
                    if (w_rise) begin
                        sr_d      = w_sr_bit[22:0];
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d = 5'd0;
                            cmd_d     = w_sr_bit[7:0];
                            case (w_sr_bit[7:0])
                                c_op_read: begin
                                    state_d = ST_ADDR;
                                    quad_d  = 1'b0;
                                end
                                c_op_qread: begin
                                    state_d = ST_ADDR;
                                    quad_d  = 1'b1;
                                end
                                c_op_prog: begin
                                    state_d = ST_ADDR;
                                    quad_d  = 1'b0;
                                end
                                c_op_qprog: begin
                                    state_d = ST_ADDR;
                                    quad_d  = 1'b1;
                                end
                                c_op_rdsr: begin
                                    state_d = ST_STATUS;
                                    tx_d    = w_status;
                                end
                                // Write-enable has no payload; it only needs
                                // its rise count checked at CS release.
                                default: state_d = ST_IGNORE;
                            endcase
                        end
                    end
                end

                ST_ADDR: begin
                    if (w_rise) begin
                        sr_d      = w_sr_bit[22:0];
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd23) begin
                            bit_cnt_d = 5'd0;
                            addr_d    = w_addr_in;
                            case (cmd_q)
                                c_op_read: begin
                                    state_d = ST_RD_DATA;
                                    rd_en_d = 1'b1;
                                end
                                c_op_qread: state_d = ST_DUMMY;
                                c_op_prog, c_op_qprog: begin
                                    state_d   = ST_WR_DATA;
                                    wr_seen_d = 1'b1;
                                end
                                default: state_d = ST_IGNORE;
                            endcase
                        end
                    end
                end

                ST_DUMMY: begin
                    if (w_rise) begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d = 5'd0;
                            state_d   = ST_RD_DATA;
                            rd_en_d   = 1'b1;
                        end
                    end
                end

                ST_RD_DATA: begin
                    if (w_fall) begin
                        if (quad_q) begin
                            io_d  = tx_q[7:4];
                            ena_d = 4'b1111;
                            tx_d  = {tx_q[3:0], 4'b0000};
                        end else begin
                            io_d  = {2'b00, tx_q[7], 1'b0};
                            ena_d = 4'b0010;
                            tx_d  = {tx_q[6:0], 1'b0};
                        end
                    end
                    if (w_rise) begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == (quad_q ? 5'd1 : 5'd7)) begin
                            bit_cnt_d = 5'd0;
                            addr_d    = addr_q + c_addr_one;
                            rd_en_d   = 1'b1;
                        end
                    end
                end

                ST_WR_DATA: begin
                    if (w_rise) begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (quad_q) begin
                            sr_d = w_sr_nib;
                            if (bit_cnt_q == 5'd1) begin
                                bit_cnt_d = 5'd0;
                                wr_en_d   = wel_q;
                                if (wel_q) begin
                                    wr_data_d = w_sr_nib[7:0];
                                end
                            end
                        end else begin
                            sr_d = w_sr_bit[22:0];
                            if (bit_cnt_q == 5'd7) begin
                                bit_cnt_d = 5'd0;
                                wr_en_d   = wel_q;
                                if (wel_q) begin
                                    wr_data_d = w_sr_bit[7:0];
                                end
                            end
                        end
                    end
                end

                ST_STATUS: begin
                    if (w_fall) begin
                        io_d  = {2'b00, tx_q[7], 1'b0};
                        ena_d = 4'b0010;
                        tx_d  = {tx_q[6:0], 1'b0};
                    end
                    if (w_rise) begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d = 5'd0;
                            tx_d      = w_status;
                        end
                    end
                end

                ST_IGNORE: begin
                    state_d = ST_IGNORE;
                end

                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sclk_q     <= 1'b1;
            // Treat CS as already low so that a CS held low through reset
            // cannot start a transaction; a fresh high-then-low is needed.
            cs_n_q     <= 1'b0;
            bit_cnt_q  <= 5'd0;
            rise_cnt_q <= 4'd0;
            sr_q       <= 23'd0;
            cmd_q      <= 8'h00;
            quad_q     <= 1'b0;
            tx_q       <= 8'h00;
            addr_q     <= '0;
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= 8'h00;
            io_q       <= 4'b0000;
            ena_q      <= 4'b0000;
            wel_q      <= 1'b0;
            wr_seen_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sclk_q     <= in_sclk;
            cs_n_q     <= in_cs_n;
            bit_cnt_q  <= bit_cnt_d;
            rise_cnt_q <= rise_cnt_d;
            sr_q       <= sr_d;
            cmd_q      <= cmd_d;
            quad_q     <= quad_d;
            tx_q       <= tx_d;
            addr_q     <= addr_d;
            rd_en_q    <= rd_en_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
            io_q       <= io_d;
            ena_q      <= ena_d;
            wel_q      <= wel_d;
            wr_seen_q  <= wr_seen_d;
        end
    end

    assign out_io          = io_q;
    assign io_ena          = ena_q;
    assign out_mem_addr    = addr_q;
    assign out_mem_rd_en   = rd_en_q;
    assign out_mem_wr_en   = wr_en_q;
    assign out_mem_wr_data = wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_spi_target.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_mem_spi_target
//  Purpose  : Directed self-checking bench for mem_spi_target. Acts as an
//             SPI initiator and a zero-latency byte memory; expected memory
//             strobes and output bytes are queued ahead of the stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_spi_target;

    localparam int ADDR_W = 24;
    localparam int HALF   = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_sclk;
    logic              in_cs_n;
    logic [3:0]        in_io;
    logic [3:0]        out_io;
    logic [3:0]        io_ena;
    logic [ADDR_W-1:0] out_mem_addr;
    logic              out_mem_rd_en;
    logic [7:0]        in_mem_rd_data;
    logic              out_mem_wr_en;
    logic [7:0]        out_mem_wr_data;

    logic [7:0]  mem [256];
    int          checks = 0;
    int          errors = 0;
    logic [23:0] exp_rd [$];
    logic [31:0] exp_wr [$];
    logic [7:0]  exp_do [$];
    logic [23:0] mon_exp_a;
    logic [31:0] mon_exp_w;

    always #5 clk = ~clk;

    assign in_mem_rd_data = mem[out_mem_addr[7:0]];

    mem_spi_target #(.ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_sclk        (in_sclk),
        .in_cs_n        (in_cs_n),
        .in_io          (in_io),
        .out_io         (out_io),
        .io_ena         (io_ena),
        .out_mem_addr   (out_mem_addr),
        .out_mem_rd_en  (out_mem_rd_en),
        .in_mem_rd_data (in_mem_rd_data),
        .out_mem_wr_en  (out_mem_wr_en),
        .out_mem_wr_data(out_mem_wr_data)
    );

    task automatic fail(input string tag);
        errors++;
        $error("FAIL %s", tag);
    endtask

    always @(negedge clk) begin
        if (rst_n && (out_mem_rd_en || out_mem_wr_en)) begin
            checks++;
            if ((out_mem_rd_en & out_mem_wr_en) !== 1'b0) fail("rd_wr_excl");
            if (out_mem_rd_en) begin
                checks++;
                if (exp_rd.size() == 0) fail("rd_unexpected");
                else begin
                    mon_exp_a = exp_rd.pop_front();
                    checks++;
                    if (out_mem_addr !== mon_exp_a) begin
                        fail("rd_addr");
                        $display("  observed=%0h expected=%0h", out_mem_addr, mon_exp_a);
                    end
                end
            end
            if (out_mem_wr_en) begin
                checks++;
                if (exp_wr.size() == 0) fail("wr_unexpected");
                else begin
                    mon_exp_w = exp_wr.pop_front();
                    checks++;
                    if (out_mem_addr !== mon_exp_w[31:8]) fail("wr_addr");
                    checks++;
                    if (out_mem_wr_data !== mon_exp_w[7:0]) fail("wr_data");
                end
            end
        end
    end

    task automatic sclk_cycle(input logic [3:0] drv, output logic [3:0] sio, output logic [3:0] sena);
        @(negedge clk);
        in_sclk = 1'b0;
        in_io   = drv;
        repeat (HALF) @(negedge clk);
        sio     = out_io;
        sena    = io_ena;
        in_sclk = 1'b1;
        repeat (HALF - 1) @(negedge clk);
    endtask

    task automatic send_single(input logic [31:0] val, input int nbits, output logic [3:0] eor);
        logic [3:0] sio, sena;
        eor = 4'h0;
        for (int i = nbits - 1; i >= 0; i--) begin
            sclk_cycle({3'b000, val[i]}, sio, sena);
            eor |= sena;
        end
    endtask

    task automatic send_quad(input logic [7:0] b, output logic [3:0] eor);
        logic [3:0] sio, sena;
        eor = 4'h0;
        sclk_cycle(b[7:4], sio, sena);
        eor |= sena;
        sclk_cycle(b[3:0], sio, sena);
        eor |= sena;
    endtask

    task automatic read_single(output logic [7:0] b, output logic [3:0] ea, output logic [3:0] eo);
        logic [3:0] sio, sena;
        b  = 8'h00;
        ea = 4'hF;
        eo = 4'h0;
        for (int i = 0; i < 8; i++) begin
            sclk_cycle(4'h0, sio, sena);
            b  = {b[6:0], sio[1]};
            ea &= sena;
            eo |= sena;
        end
    endtask

    task automatic read_quad(output logic [7:0] b, output logic [3:0] ea, output logic [3:0] eo);
        logic [3:0] sio, sena;
        ea = 4'hF;
        eo = 4'h0;
        sclk_cycle(4'h0, sio, sena);
        b[7:4] = sio;
        ea &= sena;
        eo |= sena;
        sclk_cycle(4'h0, sio, sena);
        b[3:0] = sio;
        ea &= sena;
        eo |= sena;
    endtask

    task automatic check_do(input string tag, input logic [7:0] b);
        logic [7:0] e;
        e = exp_do.pop_front();
        checks++;
        if (b !== e) begin
            fail(tag);
            $display("  observed=%0h expected=%0h", b, e);
        end
    endtask

    task automatic cs_low();
        @(negedge clk);
        in_cs_n = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic cs_high();
        @(negedge clk);
        in_cs_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] eor;
        logic [3:0] eand;
        logic [3:0] eor2;
        logic [7:0] b;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'hA5;
        mem[8'h11] = 8'h3C;
        mem[8'h12] = 8'h77;
        mem[8'hFF] = 8'h5A;
        mem[8'h00] = 8'hC3;
        mem[8'h01] = 8'h99;

        rst_n   = 1'b0;
        in_sclk = 1'b1;
        in_cs_n = 1'b1;
        in_io   = 4'h0;
        repeat (3) @(negedge clk);
        checks++; if (out_io !== 4'h0) fail("rst_out_io");
        checks++; if (io_ena !== 4'h0) fail("rst_io_ena");
        checks++; if (out_mem_addr !== 24'h000000) fail("rst_addr");
        checks++; if (out_mem_rd_en !== 1'b0) fail("rst_rd_en");
        checks++; if (out_mem_wr_en !== 1'b0) fail("rst_wr_en");
        checks++; if (out_mem_wr_data !== 8'h00) fail("rst_wr_data");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        exp_rd.push_back(24'h000010);
        exp_rd.push_back(24'h000011);
        exp_rd.push_back(24'h000012);
        exp_do.push_back(8'hA5);
        exp_do.push_back(8'h3C);
        cs_low();
        send_single(32'h03, 8, eor);
        send_single(32'h000010, 24, eor2);
        checks++; if ((eor | eor2) !== 4'h0) fail("rd_hdr_ena");
        read_single(b, eand, eor);
        check_do("rd_byte0", b);
        checks++; if ({eand, eor} !== 8'h22) fail("rd_ena0");
        read_single(b, eand, eor);
        check_do("rd_byte1", b);
        checks++; if ({eand, eor} !== 8'h22) fail("rd_ena1");
        cs_high();
        checks++; if (io_ena !== 4'h0) fail("rd_ena_after_cs");
        checks++; if (exp_rd.size() != 0) fail("rd_pending");

        cs_low();
        send_single(32'h06, 8, eor);
        cs_high();
        exp_wr.push_back({8'h00, 24'h0000FF, 8'h12});
        exp_wr.push_back({8'h00, 24'h000000, 8'h34});
        cs_low();
        send_single(32'h32, 8, eor);
        send_single(32'h0000FF, 24, eor);
        send_quad(8'h12, eor);
        send_quad(8'h34, eor2);
        checks++; if ((eor | eor2) !== 4'h0) fail("qprog_ena");
        cs_high();
        checks++; if (exp_wr.size() != 0) fail("qprog_pending");
        exp_do.push_back(8'h00);
        cs_low();
        send_single(32'h05, 8, eor);
        read_single(b, eand, eor);
        check_do("status_after_prog", b);
        checks++; if ({eand, eor} !== 8'h22) fail("status_ena");
        cs_high();

        cs_low();
        send_single(32'h02, 8, eor);
        send_single(32'h000040, 24, eor);
        send_single(32'hAB, 8, eor);
        cs_high();
        exp_do.push_back(8'h00);
        cs_low();
        send_single(32'h05, 8, eor);
        read_single(b, eand, eor);
        check_do("status_no_wel", b);
        cs_high();
        cs_low();
        send_single(32'h06, 8, eor);
        cs_high();
        exp_do.push_back(8'h02);
        exp_do.push_back(8'h02);
        cs_low();
        send_single(32'h05, 8, eor);
        read_single(b, eand, eor);
        check_do("status_wel0", b);
        read_single(b, eand, eor);
        check_do("status_wel1", b);
        cs_high();

        exp_rd.push_back(24'hFFFFFF);
        exp_rd.push_back(24'h000000);
        exp_rd.push_back(24'h000001);
        exp_do.push_back(8'h5A);
        exp_do.push_back(8'hC3);
        cs_low();
        send_single(32'h6B, 8, eor);
        send_single(32'hFFFFFF, 24, eor);
        send_single(32'h00, 8, eor);
        checks++; if (eor !== 4'h0) fail("qread_dummy_ena");
        read_quad(b, eand, eor);
        check_do("qread_byte0", b);
        checks++; if ({eand, eor} !== 8'hFF) fail("qread_ena0");
        read_quad(b, eand, eor);
        check_do("qread_byte1", b);
        checks++; if ({eand, eor} !== 8'hFF) fail("qread_ena1");
        cs_high();
        checks++; if (exp_rd.size() != 0) fail("qread_pending");

        cs_low();
        send_single(32'h06, 8, eor);
        cs_high();
        cs_low();
        send_single(32'h02, 8, eor);
        send_single(32'h000000, 24, eor);
        send_single(32'h15, 5, eor);
        cs_high();
        checks++; if (io_ena !== 4'h0) fail("abort_ena");
        checks++; if (exp_wr.size() != 0) fail("abort_wr_pending");
        exp_do.push_back(8'h00);
        cs_low();
        send_single(32'h05, 8, eor);
        read_single(b, eand, eor);
        check_do("status_after_abort", b);
        cs_high();

        cs_low();
        send_single(32'h9F, 8, eor);
        send_single($urandom_range(0, 65535), 16, eor2);
        checks++; if ((eor | eor2) !== 4'h0) fail("unknown_ena");
        cs_high();

        exp_rd.push_back(24'h000010);
        cs_low();
        send_single(32'h03, 8, eor);
        send_single(32'h000010, 24, eor);
        send_single(32'h0, 4, eor);
        checks++; if (eor !== 4'h2) fail("pre_rst_ena");
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (out_io !== 4'h0) fail("midrst_out_io");
        checks++; if (io_ena !== 4'h0) fail("midrst_io_ena");
        checks++; if (out_mem_addr !== 24'h000000) fail("midrst_addr");
        checks++; if (out_mem_rd_en !== 1'b0) fail("midrst_rd_en");
        checks++; if (out_mem_wr_en !== 1'b0) fail("midrst_wr_en");
        checks++; if (out_mem_wr_data !== 8'h00) fail("midrst_wr_data");
        rst_n = 1'b1;
        send_single(32'hFFFF, 16, eor);
        checks++; if (eor !== 4'h0) fail("post_rst_ena");
        checks++; if (out_mem_addr !== 24'h000000) fail("post_rst_addr");
        cs_high();

        exp_rd.push_back(24'h000011);
        exp_rd.push_back(24'h000012);
        exp_do.push_back(8'h3C);
        cs_low();
        send_single(32'h03, 8, eor);
        send_single(32'h000011, 24, eor);
        read_single(b, eand, eor);
        check_do("recover_byte", b);
        cs_high();
        checks++; if (exp_rd.size() != 0) fail("final_rd_pending");
        checks++; if (exp_wr.size() != 0) fail("final_wr_pending");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
